jts18_pri_mixer: RTL
====================

JTS18_PRI_MIXER -- requirements
Module: jts18_pri_mixer

Interface
REQ-001 Parameter LAYERS, default 7, number of layer inputs (range 2..15).
REQ-002 Parameter CW, default 11, colour width per layer.
REQ-003 Parameter RW, default 3, priority rank width.
REQ-004 Parameter MW, default 3, mode select width; MODES = 2**MW.
REQ-005 Derived LW = clog2(LAYERS+1), layer index width.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clk  input  1  single clock for all logic.
REQ-008 pxl_cen  input  1  pixel clock enable; the pipeline advances only when high.
REQ-009 line_start  input  1  one-pxl_cen pulse at start of each active line.
REQ-010 mode_in  input  MW  requested priority mode.
REQ-011 pri_we  input  1  rank table write strobe, one clk per write.
REQ-012 pri_addr  input  MW+LW  write address {mode, layer}.
REQ-013 pri_din  input  RW  rank written.
REQ-014 layer_opaque  input  LAYERS  bit n high = layer n pixel is opaque.
REQ-015 layer_col  input  LAYERS*CW  layer n colour at bits [n*CW +: CW].
REQ-016 back_col  input  CW  backdrop colour.
REQ-017 pxl_out  output  CW  mixed pixel colour, registered.
REQ-018 win_layer  output  LW  winning layer index; LAYERS = backdrop.
REQ-019 win_vld  output  1  high when some layer won.

Function
REQ-020 Rank table SHALL hold MODES x LAYERS entries of RW bits, held in flops.
REQ-021 On clk with pri_we high, entry {mode,layer}=pri_addr SHALL take pri_din; writes with layer >= LAYERS SHALL be ignored.
REQ-022 Writes SHALL be accepted regardless of pxl_cen.
REQ-023 mode_in SHALL be stored in a pending register on every clk.
REQ-024 The active mode SHALL load the pending mode only on a clk where line_start and pxl_cen are both high; mode_in changes mid-line SHALL NOT affect the current line.
REQ-025 Stage 1 (pxl_cen high): SHALL register layer_opaque, layer_col, back_col and the active-mode ranks of all layers.
REQ-026 Stage 2 (pxl_cen high): SHALL select, among opaque layers from stage 1, the one with the highest rank; ties SHALL go to the lowest layer index.
REQ-027 Stage 2 SHALL register pxl_out = winner colour, win_layer = winner index, win_vld = 1.
REQ-028 If no layer is opaque, stage 2 SHALL register pxl_out = back_col, win_layer = LAYERS, win_vld = 0.
REQ-029 Latency SHALL be exactly 2 pxl_cen cycles from input sample to output.
REQ-030 With pxl_cen low, all pipeline registers and outputs SHALL hold.
REQ-031 A table write in the same clk as a stage-1 sample SHALL NOT be seen by that sample (old value used); the next sample SHALL see the new value.
REQ-032 A line_start mode switch in the same clk as a stage-1 sample SHALL apply to that sample.
REQ-033 Rank comparison SHALL be unsigned over RW bits; rank 0 is lowest.

Reset
REQ-034 While rst is high: pxl_out = 0, win_layer = LAYERS, win_vld = 0, all stage registers 0.
REQ-035 Reset SHALL set every rank entry {m,n} to n (higher index wins by default), pending and active mode to 0.
REQ-036 Reset asserted mid-line SHALL clear outputs asynchronously without waiting for clk; the first valid output after release SHALL appear 2 pxl_cen later.

Verification
REQ-037 After reset, pxl_cen always 1, layer_opaque=7'b0000101, col0=0x011, col2=0x022 -> two cycles later pxl_out=0x022, win_layer=2, win_vld=1.
REQ-038 Write {mode0,layer0}=7, same inputs -> from second sample after write, pxl_out=0x011, win_layer=0.
REQ-039 Ranks of layers 1 and 3 both 5 in mode 0, layer_opaque=7'b0001010 -> win_layer=1.
REQ-040 layer_opaque=0, back_col=0x3FF -> pxl_out=0x3FF, win_layer=7, win_vld=0.
REQ-041 Mode 1 programmed with reversed ranks; mode_in=1 set mid-line -> outputs unchanged until the line_start pulse, then the reversed winner appears 2 pxl_cen later.
REQ-042 pxl_cen toggling 1-in-4 with rst pulsed mid-stream -> outputs hold between enables; on rst, outputs immediately go to reset values.

Source files
------------

// File: rtl/jts18_pri_mixer.sv
// Priority-based layer mixer: programmable per-mode rank table, two-stage pipeline
// gated by pxl_cen, highest-ranked opaque layer wins, ties go to the lowest index.
module jts18_pri_mixer #(
    parameter  int LAYERS = 7,
    parameter  int CW     = 11,
    parameter  int RW     = 3,
    parameter  int MW     = 3,
    localparam int MODES  = 2**MW,
    localparam int LW     = $clog2(LAYERS+1)
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 pxl_cen,
    input  logic                 line_start,
    input  logic [MW-1:0]        mode_in,
    input  logic                 pri_we,
    input  logic [MW+LW-1:0]     pri_addr,
    input  logic [RW-1:0]        pri_din,
    input  logic [LAYERS-1:0]    layer_opaque,
    input  logic [LAYERS*CW-1:0] layer_col,
    input  logic [CW-1:0]        back_col,
    output logic [CW-1:0]        pxl_out,
    output logic [LW-1:0]        win_layer,
    output logic                 win_vld
);

    logic [RW-1:0]        rank_q [MODES][LAYERS];
    logic [MW-1:0]        wr_mode;
    logic [LW-1:0]        wr_layer;

    logic [MW-1:0]        pend_mode_q;
    logic [MW-1:0]        act_mode_q, act_mode_d;
    logic [MW-1:0]        eff_mode;
    logic                 mode_load;

    logic [LAYERS-1:0]    s1_opaque_q;
    logic [LAYERS*CW-1:0] s1_col_q;
    logic [CW-1:0]        s1_back_q;
    logic [RW-1:0]        s1_rank_q [LAYERS];

    logic [CW-1:0]        pxl_q, pxl_d;
    logic [LW-1:0]        win_q, win_d;
    logic                 vld_q, vld_d;
    logic [RW-1:0]        best_rank;

    assign wr_mode  = pri_addr[MW+LW-1:LW];
    assign wr_layer = pri_addr[LW-1:0];

    // A line_start switch takes effect on the very sample taken in the same clk.
    assign mode_load  = line_start & pxl_cen;
    assign eff_mode   = mode_load ? pend_mode_q : act_mode_q;
    assign act_mode_d = eff_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned m = 0; m < MODES; m++)
                for (int unsigned n = 0; n < LAYERS; n++)
                    rank_q[m][n] <= RW'(n);
        end else if (pri_we) begin
            for (int unsigned m = 0; m < MODES; m++)
                for (int unsigned n = 0; n < LAYERS; n++)
                    if (wr_mode == MW'(m) && wr_layer == LW'(n))
                        rank_q[m][n] <= pri_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_mode_q <= '0;
            act_mode_q  <= '0;
        end else begin
            pend_mode_q <= mode_in;
            act_mode_q  <= act_mode_d;
        end
    end

    // Stage 1 reads the table flops directly, so a same-clk write is not seen yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_opaque_q <= '0;
            s1_col_q    <= '0;
            s1_back_q   <= '0;
            for (int unsigned n = 0; n < LAYERS; n++)
                s1_rank_q[n] <= '0;
        end else if (pxl_cen) begin
            s1_opaque_q <= layer_opaque;
            s1_col_q    <= layer_col;
            s1_back_q   <= back_col;
            for (int unsigned n = 0; n < LAYERS; n++)
                s1_rank_q[n] <= rank_q[eff_mode][n];
        end
    end

    // Strict greater-than keeps the earlier (lower) index on rank ties.
    always_comb begin
        vld_d     = 1'b0;
        best_rank = '0;
        win_d     = LW'(LAYERS);
        pxl_d     = s1_back_q;
        for (int unsigned n = 0; n < LAYERS; n++) begin
            if (s1_opaque_q[n] && (!vld_d || s1_rank_q[n] > best_rank)) begin
                vld_d     = 1'b1;
                best_rank = s1_rank_q[n];
                win_d     = LW'(n);
                pxl_d     = s1_col_q[n*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pxl_q <= '0;
            win_q <= LW'(LAYERS);
            vld_q <= 1'b0;
        end else if (pxl_cen) begin
            pxl_q <= pxl_d;
            win_q <= win_d;
            vld_q <= vld_d;
        end
    end

    assign pxl_out   = pxl_q;
    assign win_layer = win_q;
    assign win_vld   = vld_q;

endmodule
